// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - Double-dabble BCD converter for divider quotient and remainder
module div_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      q_in,
    input  logic [WIDTH-1:0]      r_in,
    input  logic                  div_by_zero,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   q_sh;
    logic [SW-1:0]   r_sh;
    logic [CW-1:0]   cnt;
    logic            dz_r;

    // Every BCD nibble is corrected from its pre-shift value; no carry between nibbles.
    function automatic logic [SW-1:0] add3(input logic [SW-1:0] v);
        logic [SW-1:0] o;
        o = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[WIDTH + 4*d +: 4] >= 4'd5)
                o[WIDTH + 4*d +: 4] = v[WIDTH + 4*d +: 4] + 4'd3;
        end
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SHIFT;
            S_SHIFT: if (cnt == CW'(WIDTH - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The done cycle still counts as busy so the host sees one contiguous window.
    always_comb begin
        busy = (state != S_IDLE) || done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            dz_r  <= 1'b0;
            done  <= 1'b0;
            q_bcd <= '0;
            r_bcd <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q_sh <= {{BW{1'b0}}, q_in};
                        r_sh <= {{BW{1'b0}}, r_in};
                        dz_r <= div_by_zero;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    q_sh <= add3(q_sh) << 1;
                    r_sh <= add3(r_sh) << 1;
                    cnt  <= cnt + 1'b1;
                end
                S_DONE: begin
                    if (dz_r) begin
                        q_bcd <= {DIGITS{4'hE}};
                        r_bcd <= {DIGITS{4'hE}};
                    end else begin
                        q_bcd <= q_sh[SW-1 -: BW];
                        r_bcd <= r_sh[SW-1 -: BW];
                    end
                    err  <= dz_r;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - Scoreboard bench for div_result_bcd
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  q_in;
    logic [7:0]  r_in;
    logic        div_by_zero;
    logic        busy;
    logic        done;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        err;

    typedef struct {
        logic [11:0] q;
        logic [11:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .q_in        (q_in),
        .r_in        (r_in),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done),
        .q_bcd       (q_bcd),
        .r_bcd       (r_bcd),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q_bcd", {20'd0, q_bcd}, {20'd0, e.q});
                check("r_bcd", {20'd0, r_bcd}, {20'd0, e.r});
                check("err", {31'd0, err}, {31'd0, e.e});
            end
        end
    end

    // Called at a negedge: start is sampled on the following rising edge.
    task automatic issue(input int q, input int r, input logic dz);
        exp_t e;
        start       = 1'b1;
        q_in        = 8'(q);
        r_in        = 8'(r);
        div_by_zero = dz;
        e.q = dz ? 12'hEEE : to_bcd(q);
        e.r = dz ? 12'hEEE : to_bcd(r);
        e.e = dz;
        sb.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        q_in        = 8'($urandom);
        r_in        = 8'($urandom);
        div_by_zero = 1'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic latency_run(input int q, input int r, input string tag);
        int lat;
        int bcnt;
        issue(q, r, 1'b0);
        lat  = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd10);
        @(negedge clk);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        q_in        = 8'd0;
        r_in        = 8'd0;
        div_by_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_q_bcd", {20'd0, q_bcd}, 32'd0);
        check("rst_r_bcd", {20'd0, r_bcd}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        latency_run(28, 4, "t200_7");
        latency_run(255, 0, "t255");

        issue(255, 37, 1'b1);
        wait_done("dz");
        @(negedge clk);
        check("err_hold", {31'd0, err}, 32'd1);
        issue(5, 6, 1'b0);
        wait_done("dz_clear");

        // Starts at E3 and E9 must be dropped.
        @(negedge clk);
        issue(100, 200, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; q_in = 8'd1; r_in = 8'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; q_in = 8'd3; r_in = 8'd4;
        @(negedge clk);
        start = 1'b0;
        check("single_done", {31'd0, done}, 32'd1);
        repeat (5) @(negedge clk);
        check("ignored_idle", {31'd0, busy}, 32'd0);

        // Reset at E4 aborts the conversion.
        issue(123, 45, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_q_bcd", {20'd0, q_bcd}, 32'd0);
        check("abort_r_bcd", {20'd0, r_bcd}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        issue(77, 8, 1'b0);
        wait_done("after_abort");

        // Back-to-back sweep; 37 is odd so r also covers 0..255.
        for (int i = 0; i < 256; i++) begin
            issue(i, (i * 37) & 255, (i % 53) == 17);
            wait_done("sweep");
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
